// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Instruction memory is combinational; fetched word is registered for decode.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic {
    S_RESET,
    S_RUN
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] pc_next;
  logic [31:0] instr_next;
  logic [31:0] pcd_next;
  logic [31:0] pcp4d_next;
  logic        valid_next;

  // Target low bits are dropped; PC stays word aligned.
  logic unused_target_lsb;
  assign unused_target_lsb = ^PCTargetE[1:0];

  assign PCPlus4F = PCF + 32'd4;

  always_comb begin
    state_next = state;
    unique case (state)
      S_RESET: state_next = rst ? S_RESET : S_RUN;
      S_RUN:   state_next = rst ? S_RESET : S_RUN;
      default: state_next = S_RESET;
    endcase
  end

  always_comb begin
    pc_next = PCF;
    if (rst)
      pc_next = RESET_PC;
    else if (PCSrcE)
      pc_next = {PCTargetE[31:2], 2'b00};
    else if (StallF)
      pc_next = PCF;
    else
      pc_next = PCPlus4F;
  end

  always_comb begin
    instr_next = InstrD;
    pcd_next   = PCD;
    pcp4d_next = PCPlus4D;
    valid_next = ValidD;
    if (rst || FlushD) begin
      instr_next = NOP_INSTR;
      pcd_next   = 32'd0;
      pcp4d_next = 32'd0;
      valid_next = 1'b0;
    end else if (!StallD) begin
      instr_next = InstrF;
      pcd_next   = PCF;
      pcp4d_next = PCPlus4F;
      valid_next = (state_next == S_RUN);
    end
  end

  always_ff @(posedge clk) begin
    state    <= state_next;
    PCF      <= pc_next;
    InstrD   <= instr_next;
    PCD      <= pcd_next;
    PCPlus4D <= pcp4d_next;
    ValidD   <= valid_next;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a combinational word-index memory.
// Memory word at address A is 32'h1000_0000 + A[31:2].
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_stage dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .InstrF(InstrF),
    .PCF(PCF), .PCPlus4F(PCPlus4F),
    .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  assign InstrF = 32'h1000_0000 + {2'b00, PCF[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (PCF !== 32'h0 || PCPlus4F !== 32'h4) begin
        errors++;
        $display("FAIL reset_pc: got %h/%h want 0/4", PCF, PCPlus4F);
      end
      checks++;
      if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'h0
          || PCPlus4D !== 32'h0) begin
        errors++;
        $display("FAIL reset_ifid: got %h %b %h %h want %h 0 0 0",
                 InstrD, ValidD, PCD, PCPlus4D, NOP);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (PCF !== 32'(4 * (i + 1))) begin
        errors++;
        $display("FAIL release_pcf[%0d]: got %h want %h",
                 i, PCF, 32'(4 * (i + 1)));
      end
      checks++;
      if (InstrD !== 32'h1000_0000 + 32'(i) || PCD !== 32'(4 * i)
          || PCPlus4D !== 32'(4 * i + 4) || ValidD !== 1'b1) begin
        errors++;
        $display("FAIL release_ifid[%0d]: got %h %h %h %b want %h %h %h 1",
                 i, InstrD, PCD, PCPlus4D, ValidD,
                 32'h1000_0000 + 32'(i), 32'(4 * i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall();
    StallF = 1'b1;
    StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (PCF !== 32'h10 || InstrD !== 32'h1000_0003 || PCD !== 32'hC
          || ValidD !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h %h %h %b want 10 10000003 c 1",
                 i, PCF, InstrD, PCD, ValidD);
      end
    end
    StallF = 1'b0;
    StallD = 1'b0;
    step();
    checks++;
    if (PCF !== 32'h14 || InstrD !== 32'h1000_0004 || PCD !== 32'h10) begin
      errors++;
      $display("FAIL stall_release: got %h %h %h want 14 10000004 10",
               PCF, InstrD, PCD);
    end
    step();
    checks++;
    if (InstrD !== 32'h1000_0005 || PCD !== 32'h14) begin
      errors++;
      $display("FAIL stall_next: got %h %h want 10000005 14", InstrD, PCD);
    end
    step();
    step();
  endtask

  task automatic test_branch();
    checks++;
    if (PCF !== 32'h20) begin
      errors++;
      $display("FAIL branch_pre: got %h want 20", PCF);
    end
    PCSrcE    = 1'b1;
    PCTargetE = 32'h40;
    FlushD    = 1'b1;
    step();
    PCSrcE = 1'b0;
    FlushD = 1'b0;
    checks++;
    if (PCF !== 32'h40 || InstrD !== NOP || ValidD !== 1'b0) begin
      errors++;
      $display("FAIL branch_flush: got %h %h %b want 40 %h 0",
               PCF, InstrD, ValidD, NOP);
    end
    step();
    checks++;
    if (InstrD !== 32'h1000_0010 || PCD !== 32'h40 || PCPlus4D !== 32'h44
        || ValidD !== 1'b1 || PCF !== 32'h44) begin
      errors++;
      $display("FAIL branch_target: got %h %h %h %b %h want 10000010 40 44 1 44",
               InstrD, PCD, PCPlus4D, ValidD, PCF);
    end
  endtask

  task automatic test_priority();
    StallF    = 1'b1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h80;
    step();
    StallF = 1'b0;
    PCSrcE = 1'b0;
    checks++;
    if (PCF !== 32'h80 || InstrD !== 32'h1000_0011) begin
      errors++;
      $display("FAIL prio_redirect_stall: got %h %h want 80 10000011",
               PCF, InstrD);
    end
    StallD = 1'b1;
    FlushD = 1'b1;
    step();
    StallD = 1'b0;
    FlushD = 1'b0;
    checks++;
    if (InstrD !== NOP || ValidD !== 1'b0 || PCD !== 32'h0
        || PCF !== 32'h84) begin
      errors++;
      $display("FAIL prio_flush_stall: got %h %b %h %h want %h 0 0 84",
               InstrD, ValidD, PCD, PCF, NOP);
    end
    PCSrcE    = 1'b1;
    PCTargetE = 32'h83;
    step();
    PCSrcE = 1'b0;
    checks++;
    if (PCF !== 32'h80 || InstrD !== 32'h1000_0021 || ValidD !== 1'b1) begin
      errors++;
      $display("FAIL prio_misaligned: got %h %h %b want 80 10000021 1",
               PCF, InstrD, ValidD);
    end
  endtask

  task automatic test_wrap();
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFFC;
    step();
    PCSrcE = 1'b0;
    checks++;
    if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: got %h %h want fffffffc 0", PCF, PCPlus4F);
    end
    step();
    checks++;
    if (PCF !== 32'h0 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0
        || InstrD !== 32'h4FFF_FFFF || ValidD !== 1'b1) begin
      errors++;
      $display("FAIL wrap_next: got %h %h %h %h %b want 0 fffffffc 0 4fffffff 1",
               PCF, PCD, PCPlus4D, InstrD, ValidD);
    end
  endtask

  task automatic test_mid_reset();
    step();
    checks++;
    if (PCF !== 32'h4 || ValidD !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: got %h %b want 4 1", PCF, ValidD);
    end
    rst       = 1'b1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h40;
    step();
    rst    = 1'b0;
    PCSrcE = 1'b0;
    checks++;
    if (PCF !== 32'h0 || PCPlus4F !== 32'h4 || InstrD !== NOP
        || PCD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin
      errors++;
      $display("FAIL midrst_vals: got %h %h %h %h %h %b want 0 4 %h 0 0 0",
               PCF, PCPlus4F, InstrD, PCD, PCPlus4D, ValidD, NOP);
    end
    step();
    checks++;
    if (PCF !== 32'h4 || InstrD !== 32'h1000_0000 || PCD !== 32'h0
        || ValidD !== 1'b1) begin
      errors++;
      $display("FAIL midrst_resume: got %h %h %h %b want 4 10000000 0 1",
               PCF, InstrD, PCD, ValidD);
    end
  endtask

  initial begin
    rst       = 1'b1;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = 32'h0;
    #2;
    test_reset();
    test_stall();
    test_branch();
    test_priority();
    test_wrap();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
